c432_key_loader: RTL and testbench

//  Provisioning end of the c432 mux-locked netlist: receives a key frame on a 1-bit valid/ready

---
 rtl/c432_key_loader.sv | 156 +++++++++++++++
 tb/tb_c432_key_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c432_key_loader.sv
// Key provisioning front end for the mux-locked c432 core: hunts for a sync byte on a
// 1-bit valid/ready stream, shifts in key + nibble-XOR checksum, and commits only verified keys.
module c432_key_loader #(
  parameter int         KEY_W   = 44,
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic             s_data,
  output logic             s_ready,
  input  logic             zap_i,
  output logic [KEY_W-1:0] key_o,
  output logic             key_valid,
  output logic             err_o,
  output logic [7:0]       err_cnt,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = $clog2(KEY_W);
  localparam int IW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {HUNT = 2'd0, KEY = 2'd1, CHK = 2'd2, COMMIT = 2'd3} state_t;

  state_t           r_state;
  logic [7:0]       r_hist;
  logic [KEY_W-1:0] r_shadow;
  logic [KEY_W-1:0] r_key;
  logic [3:0]       r_chk;
  logic [CW-1:0]    r_cnt;
  logic [IW-1:0]    r_idle;
  logic             r_key_valid;
  logic             r_err;
  logic             r_ready;
  logic [7:0]       r_err_cnt;

  // A bit transfers on a rising edge where s_valid & s_ready; a bit offered together
  // with zap_i is discarded even though s_ready stays high.
  logic       w_acc;
  logic [7:0] w_hist_next;
  logic       w_timeout;
  logic [7:0] w_err_cnt_inc;
  logic [3:0] w_chk_calc;

  assign w_acc         = s_valid & r_ready & ~zap_i;
  assign w_hist_next   = {r_hist[6:0], s_data};
  assign w_timeout     = ~s_valid & (r_idle == IW'(TIMEOUT - 1));
  assign w_err_cnt_inc = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;

  always_comb begin
    w_chk_calc = 4'h0;
    for (int j = 0; j < KEY_W / 4; j++) begin
      w_chk_calc = w_chk_calc ^ r_shadow[4*j +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= HUNT;
      r_hist      <= '0;
      r_shadow    <= '0;
      r_key       <= '0;
      r_chk       <= '0;
      r_cnt       <= '0;
      r_idle      <= '0;
      r_key_valid <= 1'b0;
      r_err       <= 1'b0;
      r_ready     <= 1'b1;
      r_err_cnt   <= '0;
    end else begin
      r_err <= 1'b0;
      if (zap_i) begin
        r_state     <= HUNT;
        r_hist      <= '0;
        r_shadow    <= '0;
        r_key       <= '0;
        r_chk       <= '0;
        r_cnt       <= '0;
        r_idle      <= '0;
        r_key_valid <= 1'b0;
        r_ready     <= 1'b1;
      end else begin
        case (r_state)
          HUNT: begin
            if (w_acc) begin
              r_hist <= w_hist_next;
              if (w_hist_next == SYNC) begin
                r_state <= KEY;
                r_cnt   <= '0;
                r_idle  <= '0;
              end
            end
          end
          KEY, CHK: begin
            if (w_acc) begin
              r_idle <= '0;
              if (r_state == KEY) begin
                r_shadow <= {r_shadow[KEY_W-2:0], s_data};
                if (r_cnt == CW'(KEY_W - 1)) begin
                  r_state <= CHK;
                  r_cnt   <= '0;
                end else begin
                  r_cnt <= r_cnt + CW'(1);
                end
              end else begin
                r_chk <= {r_chk[2:0], s_data};
                if (r_cnt == CW'(3)) begin
                  r_state <= COMMIT;
                  r_ready <= 1'b0;
                  r_cnt   <= '0;
                end else begin
                  r_cnt <= r_cnt + CW'(1);
                end
              end
            end else if (w_timeout) begin
              // Sender stalled mid-frame: drop it, keep whatever key is live.
              r_state   <= HUNT;
              r_hist    <= '0;
              r_cnt     <= '0;
              r_idle    <= '0;
              r_err     <= 1'b1;
              r_err_cnt <= w_err_cnt_inc;
            end else if (!s_valid) begin
              r_idle <= r_idle + IW'(1);
            end
          end
          COMMIT: begin
            if (r_chk == w_chk_calc) begin
              r_key       <= r_shadow;
              r_key_valid <= 1'b1;
            end else begin
              r_err     <= 1'b1;
              r_err_cnt <= w_err_cnt_inc;
            end
            r_state <= HUNT;
            r_hist  <= '0;
            r_ready <= 1'b1;
          end
          default: begin
            r_state <= HUNT;
            r_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign s_ready     = r_ready;
  assign key_o       = r_key;
  assign key_valid   = r_key_valid;
  assign err_o       = r_err;
  assign err_cnt     = r_err_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_c432_key_loader.sv
// Bench for c432_key_loader: frame-level reference model (bit queue per frame, checksum
// from nibble arithmetic) compared every cycle, plus pinned literal scenarios.
module tb_c432_key_loader;

  localparam int KEY_W   = 44;
  localparam int TIMEOUT = 1024;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s_valid;
  logic             s_data;
  logic             zap_i;
  logic             s_ready;
  logic [KEY_W-1:0] key_o;
  logic             key_valid;
  logic             err_o;
  logic [7:0]       err_cnt;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 0;

  c432_key_loader #(.KEY_W(KEY_W), .SYNC(8'hA5), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .zap_i(zap_i), .key_o(key_o), .key_valid(key_valid), .err_o(err_o),
    .err_cnt(err_cnt), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [0:0]       exp_q[$];
  logic [KEY_W-1:0] m_key = '0;
  bit               m_valid = 0;
  bit               m_err = 0;
  int               m_cnt = 0;
  bit               m_commit = 0;
  bit               m_hunting = 1;
  int               m_hist = 0;
  int               m_idle = 0;

  function automatic logic [3:0] nib_xor(input logic [KEY_W-1:0] k);
    logic [3:0] x;
    x = 4'h0;
    for (int j = 0; j < KEY_W / 4; j++) x = x ^ 4'((k >> (4 * j)) & 15);
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    logic [KEY_W-1:0] k;
    logic [3:0]       c;
    bit               acc;
    if (!rst_n) begin
      m_key = '0; m_valid = 0; m_err = 0; m_cnt = 0; m_commit = 0;
      m_hunting = 1; m_hist = 0; m_idle = 0; exp_q.delete();
    end else begin
      acc = s_valid && !m_commit && !zap_i;
      m_err = 0;
      if (zap_i) begin
        m_key = '0; m_valid = 0; m_commit = 0; m_hunting = 1;
        m_hist = 0; m_idle = 0; exp_q.delete();
      end else if (m_commit) begin
        k = '0; c = '0;
        for (int i = 0; i < KEY_W; i++) k = (k << 1) | KEY_W'(exp_q[i]);
        for (int i = 0; i < 4; i++) c = (c << 1) | 4'(exp_q[KEY_W + i]);
        if (c == nib_xor(k)) begin
          m_key = k; m_valid = 1;
        end else begin
          m_err = 1; m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
        m_commit = 0; m_hunting = 1; m_hist = 0; exp_q.delete();
      end else if (m_hunting) begin
        if (acc) begin
          m_hist = ((m_hist << 1) | int'(s_data)) & 255;
          if (m_hist == 'hA5) begin
            m_hunting = 0; m_idle = 0; exp_q.delete();
          end
        end
      end else begin
        if (acc) begin
          exp_q.push_back(s_data);
          m_idle = 0;
          if (exp_q.size() == KEY_W + 4) m_commit = 1;
        end else if (!s_valid) begin
          m_idle++;
          if (m_idle == TIMEOUT) begin
            m_err = 1; m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_hunting = 1; m_hist = 0; m_idle = 0; exp_q.delete();
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp && rst_n) begin
      check("key_o", 64'(key_o), 64'(m_key));
      check("key_valid", 64'(key_valid), 64'(m_valid));
      check("err_o", 64'(err_o), 64'(m_err));
      check("err_cnt", 64'(err_cnt), 64'(m_cnt));
      check("s_ready", 64'(s_ready), 64'(!m_commit));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    s_valid = 1'b0;
    s_data  = 1'($urandom());
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_bit(input logic d);
    bit r;
    int guard;
    guard = 0;
    s_valid = 1'b1;
    s_data  = d;
    forever begin
      r = s_ready;
      @(posedge clk); #1;
      if (r) break;
      guard++;
      if (guard > 20) begin
        checks++; errors++;
        $display("FAIL handshake_wait got stalled exp accept at %0t", $time);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [63:0] v, input int n, input int maxgap);
    for (int i = n - 1; i >= 0; i--) begin
      if (maxgap > 0)
        idle(($urandom_range(0, 9) == 0) ? $urandom_range(0, maxgap) : $urandom_range(0, 2));
      send_bit(v[i]);
    end
  endtask

  task automatic send_frame(input logic [KEY_W-1:0] k, input logic [3:0] c, input int maxgap);
    send_bits(64'hA5, 8, maxgap);
    send_bits(64'(k), KEY_W, maxgap);
    send_bits(64'(c), 4, maxgap);
  endtask

  task automatic zap_pulse();
    zap_i = 1'b1;
    @(posedge clk); #1;
    zap_i = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_key_o"}, 64'(key_o), 64'h0);
    check({tag, "_key_valid"}, 64'(key_valid), 64'h0);
    check({tag, "_err_o"}, 64'(err_o), 64'h0);
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'h0);
    check({tag, "_s_ready"}, 64'(s_ready), 64'h1);
    check({tag, "_state"}, 64'(dbg_state), 64'h0);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [KEY_W-1:0] k;
    logic [KEY_W-1:0] last_good;
    logic [63:0]      junk;
    bit               lv;
    int               mode;
    rst_n = 1'b0; s_valid = 1'b0; s_data = 1'b0; zap_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_cmp = 1;

    // Bad checksum from reset: one err pulse, key stays locked.
    send_frame(44'hFFF_FFFF_FFFF, 4'hE, 0);
    @(negedge clk);
    check("bad_commit_ready", 64'(s_ready), 64'h0);
    @(negedge clk);
    check("bad_err_o", 64'(err_o), 64'h1);
    check("bad_err_cnt", 64'(err_cnt), 64'h1);
    check("bad_key_valid", 64'(key_valid), 64'h0);
    check("bad_key_o", 64'(key_o), 64'h0);
    @(negedge clk);
    check("bad_err_pulse_end", 64'(err_o), 64'h0);

    // Good frame: key lands on the COMMIT edge, not before.
    @(posedge clk); #1;
    send_frame(44'h123_4567_89AB, 4'h0, 0);
    @(negedge clk);
    check("good_commit_ready", 64'(s_ready), 64'h0);
    check("good_not_yet", 64'(key_valid), 64'h0);
    @(negedge clk);
    check("good_key_o", 64'(key_o), 64'h123_4567_89AB);
    check("good_key_valid", 64'(key_valid), 64'h1);
    check("good_ready_back", 64'(s_ready), 64'h1);

    // Noise ahead of the sync byte is ignored.
    @(posedge clk); #1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_frame(44'h1, 4'h1, 0);
    idle(3);
    @(negedge clk);
    check("noise_key_o", 64'(key_o), 64'h1);

    // Stall mid-key past the timeout: abort, old key kept.
    @(posedge clk); #1;
    send_bits(64'hA5, 8, 0);
    send_bits(64'($urandom()), 20, 0);
    idle(TIMEOUT + 3);
    @(negedge clk);
    check("timeout_err_cnt", 64'(err_cnt), 64'h2);
    check("timeout_key_o", 64'(key_o), 64'h1);
    check("timeout_key_valid", 64'(key_valid), 64'h1);

    // Zap wipes the key, not the error count.
    @(posedge clk); #1;
    zap_pulse();
    @(negedge clk);
    check("zap_key_o", 64'(key_o), 64'h0);
    check("zap_key_valid", 64'(key_valid), 64'h0);
    check("zap_err_cnt", 64'(err_cnt), 64'h2);
    @(posedge clk); #1;

    // Randomized frames with gaps, corrupted checksums, zaps and one async reset.
    last_good = '0; lv = 0;
    for (int f = 0; f < 24; f++) begin
      k = KEY_W'({$urandom(), $urandom()});
      repeat ($urandom_range(0, 4)) send_bit(1'($urandom()));
      mode = (f == 10) ? 99 : $urandom_range(0, 9);
      if (mode == 99) begin
        send_bits(64'hA5, 8, 6);
        send_bits(64'(k), 20, 6);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_good = '0; lv = 0;
      end else if (mode <= 1) begin
        junk = {$urandom(), $urandom()};
        send_bits(64'hA5, 8, 6);
        send_bits(junk, $urandom_range(0, KEY_W + 3), 6);
        zap_pulse();
        last_good = '0; lv = 0;
      end else if (mode <= 3) begin
        send_frame(k, nib_xor(k) ^ 4'($urandom_range(1, 15)), 40);
      end else begin
        send_frame(k, nib_xor(k), 40);
        last_good = k; lv = 1;
      end
      idle(3);
      @(negedge clk);
      check("rand_key_o", 64'(key_o), 64'(last_good));
      check("rand_key_valid", 64'(key_valid), 64'(lv));
      @(posedge clk); #1;
    end

    // Enough bad frames to pin the error counter at its ceiling.
    for (int f = 0; f < 260; f++) begin
      k = KEY_W'({$urandom(), $urandom()});
      send_frame(k, ~nib_xor(k), 0);
    end
    idle(3);
    @(negedge clk);
    check("sat_err_cnt", 64'(err_cnt), 64'hFF);
    check("sat_key_o", 64'(key_o), 64'(last_good));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
